hazard_sequencer: RTL

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

---
 rtl/hazard_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use stalls, taken-branch flushes and halt,
// with saturating event counters. Outputs are Mealy on state and inputs.
module hazard_sequencer #(
  parameter int unsigned CNT_W   = 16,
  parameter logic [5:0]  HALT_OP = 6'd63
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [5:0]       if_id_opcode_i,
  input  logic [4:0]       if_id_rs_i,
  input  logic [4:0]       if_id_rt_i,
  input  logic             id_ex_mem_read_i,
  input  logic [4:0]       id_ex_rt_i,
  input  logic             ex_branch_taken_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] flush_count_o
);

  typedef enum logic [1:0] {StRun, StStall, StFlush, StHalt} state_e;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic rs_used, rt_used, load_use;
  logic stall_inc, flush_inc;

  always_comb begin
    rs_used = 1'b0;
    rt_used = 1'b0;
    case (if_id_opcode_i)
      6'd1, 6'd2, 6'd3, 6'd7, 6'd9, 6'd10: begin
        rs_used = 1'b1;
        rt_used = 1'b1;
      end
      6'd5, 6'd6: rs_used = 1'b1;
      default: ;
    endcase
    load_use = id_ex_mem_read_i && (id_ex_rt_i != 5'd0) &&
               ((rs_used && (id_ex_rt_i == if_id_rs_i)) ||
                (rt_used && (id_ex_rt_i == if_id_rt_i)));
  end

  always_comb begin
    state_d       = state_q;
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    halted_o      = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;

    if (state_q == StHalt) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      id_ex_flush_o = 1'b1;
      halted_o      = 1'b1;
    end else if (ex_branch_taken_i) begin
      // A taken branch outranks every other event, in any non-halt state.
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      flush_inc     = 1'b1;
      state_d       = StFlush;
    end else if (state_q == StRun) begin
      if (load_use) begin
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        id_ex_flush_o = 1'b1;
        stall_inc     = 1'b1;
        state_d       = StStall;
      end else if (if_id_opcode_i == HALT_OP) begin
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        id_ex_flush_o = 1'b1;
        state_d       = StHalt;
      end
    end else begin
      // STALL/FLUSH: ID content is stale or a bubble, so hazards are ignored.
      state_d = StRun;
    end

    if (!rst_ni) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      halted_o      = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CntOne;
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CntOne;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;

endmodule
